// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU execute unit:
// aluop/funct codes, internal op enum, FSM states, decoder.
package alu_pkg;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_SLT   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
        OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_DIV, OP_ILLEGAL
    } op_e;

    // sgn selects signed mult/div; var_sh takes the amount from a
    typedef struct packed {
        op_e  op;
        logic sgn;
        logic var_sh;
    } dec_t;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

    function automatic dec_t decode(input logic [1:0] aluop,
                                    input logic [5:0] funct);
        dec_t d;
        d = '{op: OP_ILLEGAL, sgn: 1'b1, var_sh: 1'b0};
        case (aluop)
            AOP_ADD: d.op = OP_ADD;
            AOP_SUB: d.op = OP_SUB;
            AOP_SLT: d.op = OP_SLT;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: d.op = OP_ADD;
                    F_SUB, F_SUBU: d.op = OP_SUB;
                    F_AND:  d.op = OP_AND;
                    F_OR:   d.op = OP_OR;
                    F_XOR:  d.op = OP_XOR;
                    F_NOR:  d.op = OP_NOR;
                    F_SLT:  d.op = OP_SLT;
                    F_SLTU: d.op = OP_SLTU;
                    F_SLL:  d.op = OP_SLL;
                    F_SRL:  d.op = OP_SRL;
                    F_SRA:  d.op = OP_SRA;
                    F_SLLV: begin d.op = OP_SLL; d.var_sh = 1'b1; end
                    F_SRLV: begin d.op = OP_SRL; d.var_sh = 1'b1; end
                    F_SRAV: begin d.op = OP_SRA; d.var_sh = 1'b1; end
                    F_MFHI: d.op = OP_MFHI;
                    F_MTHI: d.op = OP_MTHI;
                    F_MFLO: d.op = OP_MFLO;
                    F_MTLO: d.op = OP_MTLO;
                    F_MULT:  d.op = OP_MULT;
                    F_MULTU: begin d.op = OP_MULT; d.sgn = 1'b0; end
                    F_DIV:   d.op = OP_DIV;
                    F_DIVU:  begin d.op = OP_DIV; d.sgn = 1'b0; end
                    default: d.op = OP_ILLEGAL;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative engine: shift-add multiply / restoring divide on
// magnitudes, one step per clock, sign fix-up on the outputs.
module muldiv_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic                 div_q, neg_q, negr_q, dz_q;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       sum, sh, diff;
    logic                 ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    assign a_abs = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign done_o = step_i && (cnt_q == SHAMT_W'(WIDTH-1));

    // One multiply or divide iteration on the accumulator pair
    always_comb begin
        sum  = q_q[0] ? acc_q + {1'b0, m_q} : acc_q;
        sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        ge   = sh >= {1'b0, m_q};
        diff = sh - {1'b0, m_q};
        if (div_q) begin
            acc_d = ge ? diff : sh;
            q_d   = {q_q[WIDTH-2:0], ge};
        end else begin
            {acc_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up; divide by zero forces an all-ones quotient
    always_comb begin
        prod = {acc_q[WIDTH-1:0], q_q};
        if (neg_q) prod = -prod;
        quo  = neg_q ? -q_q : q_q;
        rem  = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (div_q) begin
            hi_o = rem;
            lo_o = dz_q ? '1 : quo;
        end else begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end
    end

    // Operand latch on start, then one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (start_i) begin
            acc_q  <= '0;
            q_q    <= a_abs;
            m_q    <= b_abs;
            cnt_q  <= '0;
            div_q  <= div_i;
            neg_q  <= sgn_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negr_q <= sgn_i && a_i[WIDTH-1];
            dz_q   <= (b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Multicycle ALU execute unit: decode, single-cycle datapath,
// HI/LO registers and the outer FSM around muldiv_iter.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         aluop,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               done,
    output logic               busy,
    output logic               illegal,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_e             state_q, state_d;
    dec_t               dec;
    logic               is_md, accept;
    logic               md_start, md_step, md_done, fix;
    logic [WIDTH-1:0]   md_hi, md_lo;
    logic [SHAMT_W-1:0] sh_amt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic               zero_q, done_q, illegal_q;

    assign dec    = decode(aluop, funct);
    assign is_md  = (dec.op == OP_MULT) || (dec.op == OP_DIV);
    assign accept = start && (state_q == S_IDLE);
    assign sh_amt = dec.var_sh ? a[SHAMT_W-1:0] : shamt;

    // Single-cycle datapath
    always_comb begin
        alu_res = '0;
        case (dec.op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
            OP_SLTU: alu_res[0] = a < b;
            OP_SLL:  alu_res = b << sh_amt;
            OP_SRL:  alu_res = b >> sh_amt;
            OP_SRA:  alu_res = $signed(b) >>> sh_amt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI, OP_MTLO: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_md) state_d = S_ITER;
            S_ITER:  if (md_done) state_d = S_FIX;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (state_q != S_IDLE);
        md_start = accept && is_md;
        md_step  = (state_q == S_ITER);
        fix      = (state_q == S_FIX);
    end

    muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_md (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (md_start),
        .step_i  (md_step),
        .div_i   (dec.op == OP_DIV),
        .sgn_i   (dec.sgn),
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // Architectural result, flags and HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (fix) begin
                hi_q     <= md_hi;
                lo_q     <= md_lo;
                result_q <= md_lo;
                zero_q   <= (md_lo == '0);
                done_q   <= 1'b1;
            end else if (accept && !is_md) begin
                result_q  <= alu_res;
                zero_q    <= (alu_res == '0);
                done_q    <= 1'b1;
                illegal_q <= (dec.op == OP_ILLEGAL);
                if (dec.op == OP_MTHI) hi_q <= a;
                if (dec.op == OP_MTLO) lo_q <= a;
            end
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed steps plus random
// ops against a plain-arithmetic reference model.
module tb_alu_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    aluop;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic [4:0]    shamt;
    logic [W-1:0]  result, hi, lo;
    logic          zero, done, busy, illegal;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .aluop   (aluop),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .shamt   (shamt),
        .result  (result),
        .zero    (zero),
        .done    (done),
        .busy    (busy),
        .illegal (illegal),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics in plain integer arithmetic
    task automatic model(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] ta, input logic [31:0] tb,
                         input logic [4:0] sh, output logic [31:0] r,
                         output logic ill, output logic mul);
        int          sa, sb;
        longint      la, lb;
        logic [63:0] p;
        sa = ta; sb = tb; la = sa; lb = sb;
        r = 0; ill = 0; mul = 0;
        if (op == 2'b00) r = ta + tb;
        else if (op == 2'b01) r = ta - tb;
        else if (op == 2'b11) r = (sa < sb) ? 1 : 0;
        else begin
            case (fn)
                6'h20, 6'h21: r = ta + tb;
                6'h22, 6'h23: r = ta - tb;
                6'h24: r = ta & tb;
                6'h25: r = ta | tb;
                6'h26: r = ta ^ tb;
                6'h27: r = ~(ta | tb);
                6'h2a: r = (sa < sb) ? 1 : 0;
                6'h2b: r = (ta < tb) ? 1 : 0;
                6'h00: r = tb << sh;
                6'h02: r = tb >> sh;
                6'h03: r = sb >>> sh;
                6'h04: r = tb << ta[4:0];
                6'h06: r = tb >> ta[4:0];
                6'h07: r = sb >>> ta[4:0];
                6'h10: r = m_hi;
                6'h12: r = m_lo;
                6'h11: begin m_hi = ta; r = ta; end
                6'h13: begin m_lo = ta; r = ta; end
                6'h18, 6'h19: begin
                    if (fn == 6'h18) p = la * lb;
                    else p = {32'b0, ta} * {32'b0, tb};
                    m_hi = p[63:32]; m_lo = p[31:0];
                    r = m_lo; mul = 1;
                end
                6'h1a, 6'h1b: begin
                    if (tb == 0) begin
                        m_lo = 32'hFFFFFFFF; m_hi = ta;
                    end else if (fn == 6'h1a) begin
                        m_lo = 32'(la / lb); m_hi = 32'(la % lb);
                    end else begin
                        m_lo = ta / tb; m_hi = ta % tb;
                    end
                    r = m_lo; mul = 1;
                end
                default: ill = 1;
            endcase
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] ta, input logic [31:0] tb,
                          input logic [4:0] sh);
        logic [31:0] er;
        logic        eill, emul;
        int          cyc, lim;
        model(op, fn, ta, tb, sh, er, eill, emul);
        @(negedge clk);
        chk("done_idle", 32'(done), 0);
        aluop = op; funct = fn; a = ta; b = tb; shamt = sh;
        start = 1;
        @(negedge clk);
        start = 0;
        a = $urandom; b = $urandom; shamt = 5'($urandom);
        cyc = 1;
        lim = emul ? W + 2 : 1;
        while (!done && cyc < lim + 5) begin
            chk("busy", 32'(busy), 32'(emul));
            @(negedge clk);
            cyc++;
        end
        chk("done_cyc", 32'(cyc), 32'(lim));
        chk("result", result, er);
        chk("zero", 32'(zero), 32'(er == 0));
        chk("illegal", 32'(illegal), 32'(eill));
        chk("busy_done", 32'(busy), 0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    logic [5:0]  fl [0:23] = '{
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};

    initial begin
        logic [31:0] er, ta, tb;
        logic        eill, emul;
        logic [1:0]  op;
        logic [5:0]  fn;
        int          dones;

        reset = 0; start = 0; aluop = 0; funct = 0;
        a = 0; b = 0; shamt = 0; m_hi = 0; m_lo = 0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1;

        run_op(2'b10, 6'h22, 5, 7, 0);
        chk("sub_const", result, 32'hFFFFFFFE);
        run_op(2'b10, 6'h03, 32'h80000000, 32'h80000000, 4);
        run_op(2'b10, 6'h03, 0, 32'h80000000, 4);
        chk("sra_const", result, 32'hF8000000);

        run_op(2'b10, 6'h18, 32'hFFFFFFFD, 7, 0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        run_op(2'b10, 6'h10, 0, 0, 0);
        chk("mfhi_const", result, 32'hFFFFFFFF);
        run_op(2'b10, 6'h1a, -7, 2, 0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_op(2'b10, 6'h1b, 9, 0, 0);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 9);
        run_op(2'b10, 6'h1a, -9, 0, 0);
        run_op(2'b10, 6'h1a, 32'h80000000, -1, 0);
        run_op(2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 1);

        // stray start mid-mult, then mfhi in the done cycle
        model(2'b10, 6'h18, 32'h12345678, 32'hFEDCBA98, 0,
              er, eill, emul);
        @(negedge clk);
        aluop = 2'b10; funct = 6'h18;
        a = 32'h12345678; b = 32'hFEDCBA98; start = 1;
        @(negedge clk);
        start = 0;
        dones = 0;
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            if (done) dones++;
            if (cyc == 5) begin
                aluop = 2'b00; a = 1; b = 2; start = 1;
            end
            if (cyc == 6) start = 0;
            @(negedge clk);
        end
        chk("b2b_early_done", 32'(dones), 0);
        chk("b2b_done", 32'(done), 1);
        chk("b2b_hi", hi, m_hi);
        chk("b2b_lo", lo, m_lo);
        chk("b2b_result", result, er);
        model(2'b10, 6'h10, 0, 0, 0, er, eill, emul);
        aluop = 2'b10; funct = 6'h10; start = 1;
        @(negedge clk);
        start = 0;
        chk("b2b_mfhi_done", 32'(done), 1);
        chk("b2b_mfhi", result, er);
        @(negedge clk);
        chk("b2b_single_pulse", 32'(done), 0);

        // reset in the middle of a divide
        aluop = 2'b10; funct = 6'h1a; a = 100; b = 7; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        reset = 0;
        #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_zero", 32'(zero), 1);
        m_hi = 0; m_lo = 0;
        @(negedge clk);
        reset = 1;
        run_op(2'b10, 6'h2b, 1, 32'hFFFFFFFF, 0);
        chk("sltu_const", result, 1);

        run_op(2'b10, 6'h11, 32'hA5A5_0001, 0, 0);
        run_op(2'b10, 6'h3f, 3, 4, 0);
        chk("illegal_const", 32'(illegal), 1);
        run_op(2'b11, 0, -1, 0, 0);
        chk("slti_const", result, 1);

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                             : 2'b10;
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                             : fl[$urandom_range(0, 23)];
            ta = $urandom;
            tb = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
            if ($urandom_range(0, 3) == 0) tb = tb >> $urandom_range(0, 31);
            run_op(op, fn, ta, tb, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Parametrised multi-cycle ALU execute unit for the multicycle MIPS datapath. It merges ALU control decoding with execution and adds shifts, unsigned compares, and the HI/LO register pair. It also adds iterative multiply and divide. Operands are sampled on a start/done handshake. Single-cycle ops complete in one clock; MULT/DIV ops take WIDTH+2 clocks, and the controller FSM stalls on busy.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (≥ 8, power of two)
- SHAMT_W, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch operation; sampled only when busy = 0
- aluop  in  2  00 add, 01 sub, 10 decode funct, 11 slt (slti)
- funct  in  6  R-type funct field, used when aluop = 10
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate)
- shamt  in  SHAMT_W  shift amount for sll/srl/sra
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- done  out  1  one-cycle pulse when result, hi and lo are valid
- busy  out  1  iterative operation in progress
- illegal  out  1  pulses with done on an undefined funct
- hi, lo  out  WIDTH each  HI/LO architectural registers

## Operation
- Reset values: result 0, zero 1, done 0, busy 0, illegal 0, hi 0, lo 0, state IDLE.
- Supported funct codes:
  - add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010 (signed), sltu 101011. Both produce 1 or 0 in bit 0.
  - sll 000000, srl 000010, sra 000011, all using shamt. sllv 000100, srlv 000110, srav 000111, all using a[SHAMT_W-1:0].
  - mfhi 010000 and mflo 010010 return hi or lo.
  - mthi 010001 and mtlo 010011 write a into hi or lo. Their result is a.
  - mult 011000, multu 011001, div 011010, divu 011011.
- Arithmetic is modulo 2^WIDTH. There are no overflow traps, so add and addu behave identically.
- Shift operands are b. Shift amount is taken modulo WIDTH.
- Multiply writes the 2·WIDTH-bit product to {hi, lo}.
- Divide writes the quotient to lo and the remainder to hi.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: lo = all ones, hi = a. No trap.
- After mult/div, result = new lo, and zero follows result.
- Undefined funct: result 0, zero 1, illegal = 1 with done. hi and lo are unchanged.
- FSM states:
  - IDLE. start with a single-cycle op: register result and pulse done, remain in IDLE. start with mult/div: latch |a| and |b| (or raw values if unsigned) and the sign flags, go to ITER.
  - ITER. Run WIDTH iterations of shift-add (mult) or restoring subtract-shift (div), one iteration per clock. A counter runs 0..WIDTH-1; at WIDTH-1 go to FIX.
  - FIX. Negate the product, quotient or remainder as the sign rules require. Go to IDLE; write hi, lo and result, and pulse done.
- busy = 1 in ITER and FIX. start is ignored while busy = 1.

## Timing
- Reference: start is high in cycle 0.
- Single-cycle op: result, zero, hi/lo (mthi/mtlo) and done are valid in cycle 1; busy stays 0.
- Mult/div:
  - busy is high in cycles 1..WIDTH+1 (ITER in 1..WIDTH, FIX in WIDTH+1).
  - done, result, hi and lo update in cycle WIDTH+2, which is 34 for WIDTH = 32.
- done is high for exactly one cycle per accepted start.
- A start in the same cycle done is high is accepted (state is IDLE); back-to-back ops therefore run without a gap.
- Operand inputs may change after cycle 0; the operation uses the latched values.
- mfhi/mflo issued in the done cycle of a mult/div observe the new hi/lo in their own result, one cycle later.
- Reset asserted mid-operation: all outputs return to reset values immediately and the operation is lost. The first start after reset release is accepted.

## Structure
- Package alu_pkg holds:
  - funct localparams and aluop encodings
  - the internal op enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MTHI, MFLO, MTLO, MULT, DIV, ILLEGAL) plus signed/unsigned and variable-shift flags
  - the FSM state enum (IDLE, ITER, FIX)
  - a decode function mapping {aluop, funct} to op
- Sub-module muldiv_iter holds the iterative engine: accumulator, shift registers, counter and sign fix-up, with start/done toward alu_exec. Top-level alu_exec contains the decode, the single-cycle datapath, hi/lo and the outer FSM.

## Test plan
- aluop=10, funct=100010, a=5, b=7 → cycle 1: result 0xFFFFFFFE, zero 0, done 1, busy 0. Then sra with b=0x80000000, shamt=4 → 0xF8000000.
- mult a=0xFFFFFFFD (−3), b=7 → busy cycles 1..33; cycle 34: done, hi 0xFFFFFFFF, lo 0xFFFFFFEB. A following mfhi → result 0xFFFFFFFF.
- div a=−7, b=2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. divu a=9, b=0 → lo 0xFFFFFFFF, hi 9. multu 0xFFFFFFFF×0xFFFFFFFF → hi 0xFFFFFFFE, lo 1.
- start pulsed in cycle 5 of a mult → ignored, with exactly one done (cycle 34). A new start in cycle 34 is accepted: its done comes in cycle 35 for a single-cycle op.
- reset low in cycle 10 of a div → result 0, hi 0, lo 0, busy 0 immediately. After release, sltu a=1, b=0xFFFFFFFF → result 1.
- funct=111111 → cycle 1: result 0, zero 1, illegal 1, done 1, hi/lo unchanged. aluop=11, a=−1, b=0 → result 1.
